// File: rtl/buffer_8bit_to_10bit_if.sv
// Byte-in / 10-bit-word-out bus for the receive-side 8b->10b unpacker.
interface buffer_8bit_to_10bit_if;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 10;
   localparam int unsigned CNT_W  = 8;

   logic [BYTE_W-1:0] data_in;
   logic              align;
   logic [WORD_W-1:0] data_out;
   logic              valid;
   logic              locked;
   logic              align_err;
   logic [CNT_W-1:0]  align_err_cnt;

   modport master (
      output data_in, align,
      input  data_out, valid, locked, align_err, align_err_cnt
   );

   modport slave (
      input  data_in, align,
      output data_out, valid, locked, align_err, align_err_cnt
   );
endinterface

// File: rtl/buffer_8bit_to_10bit.sv
// Receive unpacker: rebuilds 10-bit words from a gapless byte stream (5 bytes = 4 words).
// Optional misalignment checker enabled by defining BUFFER_8TO10_ALIGN_CHECK_EN.
module buffer_8bit_to_10bit #(
   parameter int unsigned OUT_PIPE = 0
) (
   input logic                   clk,
   input logic                   rst_n,
   buffer_8bit_to_10bit_if.slave bus
);
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned WORD_W  = 10;
   localparam int unsigned PH_W    = 3;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned LAST_PH = 4;
   localparam int unsigned DEPTH   = OUT_PIPE + 1;

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } state_t;

   state_t            state;
   logic [PH_W-1:0]   ph;
   logic [BYTE_W-1:0] in_byte;
   logic [BYTE_W-1:0] prev_byte;
   logic              in_align;

   logic              lock_c;
   logic              emit_c;
   logic [PH_W-1:0]   cur_ph_c;
   logic [PH_W-1:0]   ph_nxt_c;
   logic [WORD_W-1:0] word_c;

   logic [WORD_W-1:0] word_s2;
   logic              valid_s2;
   logic              locked_s2;

   logic [WORD_W-1:0] data_pl   [DEPTH];
   logic              valid_pl  [DEPTH];
   logic              locked_pl [DEPTH];

   // Registered input stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_byte  <= '0;
         in_align <= 1'b0;
      end else begin
         in_byte  <= bus.data_in;
         in_align <= bus.align;
      end
   end

   // Phase of the byte in the input stage and the word it completes
   always_comb begin
      lock_c   = (state == ST_LOCKED) || in_align;
      cur_ph_c = in_align ? '0 : ph;
      emit_c   = lock_c && (cur_ph_c != '0);
      ph_nxt_c = (cur_ph_c == PH_W'(LAST_PH)) ? '0 : cur_ph_c + PH_W'(1);
      word_c   = '0;
      case (cur_ph_c)
         PH_W'(1): word_c = {in_byte[1:0], prev_byte};
         PH_W'(2): word_c = {in_byte[3:0], prev_byte[7:2]};
         PH_W'(3): word_c = {in_byte[5:0], prev_byte[7:4]};
         PH_W'(4): word_c = {in_byte,      prev_byte[7:6]};
         default:  word_c = '0;
      endcase
   end

   // Lock state, phase counter and byte history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_UNLOCKED;
         ph        <= '0;
         prev_byte <= '0;
      end else begin
         if (lock_c) begin
            state <= ST_LOCKED;
         end
         ph        <= lock_c ? ph_nxt_c : '0;
         prev_byte <= in_byte;
      end
   end

   // Word assembly register; holds the last word between valids
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_s2   <= '0;
         valid_s2  <= 1'b0;
         locked_s2 <= 1'b0;
      end else begin
         if (emit_c) begin
            word_s2 <= word_c;
         end
         valid_s2  <= emit_c;
         locked_s2 <= lock_c;
      end
   end

   // Output register plus OUT_PIPE retiming stages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            data_pl[i]   <= '0;
            valid_pl[i]  <= 1'b0;
            locked_pl[i] <= 1'b0;
         end
      end else begin
         data_pl[0]   <= word_s2;
         valid_pl[0]  <= valid_s2;
         locked_pl[0] <= locked_s2;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            data_pl[i]   <= data_pl[i-1];
            valid_pl[i]  <= valid_pl[i-1];
            locked_pl[i] <= locked_pl[i-1];
         end
      end
   end

   assign bus.data_out = data_pl[DEPTH-1];
   assign bus.valid    = valid_pl[DEPTH-1];
   assign bus.locked   = locked_pl[DEPTH-1];

`ifdef BUFFER_8TO10_ALIGN_CHECK_EN
   logic             err_c;
   logic             err_s2;
   logic             err_tail_c;
   logic             err_pl [DEPTH];
   logic [CNT_W-1:0] err_cnt;

   // Align arriving while locked but off the group boundary
   assign err_c = in_align && (state == ST_LOCKED) && (ph != '0);

   generate
      if (DEPTH == 1) begin : g_tail_s2
         assign err_tail_c = err_s2;
      end else begin : g_tail_pl
         assign err_tail_c = err_pl[DEPTH-2];
      end
   endgenerate

   // Pulse follows its byte down the pipe; counter steps with the pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_s2  <= 1'b0;
         err_cnt <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            err_pl[i] <= 1'b0;
         end
      end else begin
         err_s2    <= err_c;
         err_pl[0] <= err_s2;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            err_pl[i] <= err_pl[i-1];
         end
         if (err_tail_c && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.align_err     = err_pl[DEPTH-1];
   assign bus.align_err_cnt = err_cnt;
`else
   assign bus.align_err     = 1'b0;
   assign bus.align_err_cnt = '0;
`endif

endmodule

// File: tb/tb_buffer_8bit_to_10bit.sv
// Bench for buffer_8bit_to_10bit: OUT_PIPE=0 and OUT_PIPE=2 instances share one byte stream.
module tb_buffer_8bit_to_10bit;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din;
   logic       ain;

   always #5 clk = ~clk;

   buffer_8bit_to_10bit_if bus0 ();
   buffer_8bit_to_10bit_if bus2 ();

   assign bus0.data_in = din;
   assign bus0.align   = ain;
   assign bus2.data_in = din;
   assign bus2.align   = ain;

   buffer_8bit_to_10bit #(.OUT_PIPE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   buffer_8bit_to_10bit #(.OUT_PIPE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

   typedef struct {
      int         due;
      logic [9:0] w;
   } exp_t;

   typedef struct {
      logic [7:0] b;
      logic       a;
      logic       v;
      logic [9:0] w;
   } vec_t;

   localparam int HIST = 4096;

   exp_t       q0[$];
   exp_t       q2[$];
   bit         lock_h [HIST];
   bit         err_h  [HIST];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         edge_n = 0;
   int         last_rst_edge = 0;
   bit         m_locked;
   int         m_ph;
   logic [39:0] m_grp;
   logic [9:0] last0, last2;
   int         ecnt0, ecnt2;
   int         vcnt0, lk_seen0;
   logic [9:0] cap0[$];

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // Reference model: group bit vector filled LSB-first, words sliced out of it
   task automatic model_push(input logic [7:0] b, input logic a);
      int         s;
      bit         err;
      int         k;
      logic [9:0] w;
      s   = edge_n + 1;
      err = m_locked && a && (m_ph != 0);
      if (a) begin
         m_locked = 1'b1;
         m_ph     = 0;
      end
      if (m_locked) begin
         m_grp[8*m_ph +: 8] = b;
         if (m_ph != 0) begin
            k = m_ph - 1;
            w = m_grp[10*k +: 10];
            q0.push_back('{due: s + 2, w: w});
            q2.push_back('{due: s + 4, w: w});
         end
         m_ph = (m_ph + 1) % 5;
      end
      if (s < HIST) begin
         lock_h[s] = m_locked;
`ifdef BUFFER_8TO10_ALIGN_CHECK_EN
         err_h[s] = err;
`else
         err_h[s] = 1'b0;
`endif
      end
   endtask

   task automatic check_one(input int which);
      logic [9:0] dout;
      logic       v, lk, er;
      logic [7:0] cnt;
      int         p, s, ec;
      bit         hv, exp_lk, exp_er;
      exp_t       head;
      logic [9:0] last;
      string      tag;
      head = '{due: 0, w: '0};
      if (which == 0) begin
         dout = bus0.data_out; v = bus0.valid; lk = bus0.locked;
         er = bus0.align_err; cnt = bus0.align_err_cnt;
         p = 0; last = last0; ec = ecnt0; tag = "p0";
         hv = (q0.size() > 0) && (q0[0].due == edge_n);
         if (hv) head = q0.pop_front();
      end else begin
         dout = bus2.data_out; v = bus2.valid; lk = bus2.locked;
         er = bus2.align_err; cnt = bus2.align_err_cnt;
         p = 2; last = last2; ec = ecnt2; tag = "p2";
         hv = (q2.size() > 0) && (q2[0].due == edge_n);
         if (hv) head = q2.pop_front();
      end
      check_eq({tag, " valid"}, 32'(v), 32'(hv));
      if (hv) begin
         check_eq({tag, " word"}, 32'(dout), 32'(head.w));
         last = head.w;
      end else begin
         check_eq({tag, " hold"}, 32'(dout), 32'(last));
      end
      s = edge_n - 2 - p;
      exp_lk = (s > last_rst_edge && s < HIST) ? lock_h[s] : 1'b0;
      exp_er = (s > last_rst_edge && s < HIST) ? err_h[s]  : 1'b0;
      check_eq({tag, " locked"}, 32'(lk), 32'(exp_lk));
      check_eq({tag, " align_err"}, 32'(er), 32'(exp_er));
      if (exp_er && ec < 255) ec++;
      check_eq({tag, " err_cnt"}, 32'(cnt), 32'(ec));
      if (which == 0) begin
         last0 = last; ecnt0 = ec;
         if (v) begin
            vcnt0++;
            cap0.push_back(dout);
         end
         if (lk) lk_seen0++;
      end else begin
         last2 = last; ecnt2 = ec;
      end
   endtask

   task automatic cycle(input logic [7:0] b, input logic a);
      din = b;
      ain = a;
      model_push(b, a);
      @(posedge clk);
      edge_n++;
      #1;
      check_one(0);
      check_one(1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      din   = '0;
      ain   = 1'b0;
      #1;
      check_eq("rst p0 data_out", 32'(bus0.data_out), 32'h0);
      check_eq("rst p0 valid", 32'(bus0.valid), 32'h0);
      check_eq("rst p0 locked", 32'(bus0.locked), 32'h0);
      check_eq("rst p0 align_err", 32'(bus0.align_err), 32'h0);
      check_eq("rst p0 err_cnt", 32'(bus0.align_err_cnt), 32'h0);
      check_eq("rst p2 data_out", 32'(bus2.data_out), 32'h0);
      check_eq("rst p2 valid", 32'(bus2.valid), 32'h0);
      check_eq("rst p2 locked", 32'(bus2.locked), 32'h0);
      q0.delete(); q2.delete(); cap0.delete();
      m_locked = 1'b0; m_ph = 0; m_grp = '0;
      last0 = '0; last2 = '0; ecnt0 = 0; ecnt2 = 0;
      repeat (2) begin
         @(posedge clk);
         edge_n++;
      end
      last_rst_edge = edge_n;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
      $fatal(1);
   end

   initial begin
      vec_t       t1[10];
      logic [9:0] exp4[5];
      int         a_edge, first_edge;
      bit         lk_low;
      logic [7:0] exp_cnt;

      t1[0] = '{b: 8'h01, a: 1'b1, v: 1'b0, w: 10'h000};
      t1[1] = '{b: 8'h02, a: 1'b0, v: 1'b0, w: 10'h000};
      t1[2] = '{b: 8'h03, a: 1'b0, v: 1'b0, w: 10'h000};
      t1[3] = '{b: 8'h04, a: 1'b0, v: 1'b1, w: 10'h201};
      t1[4] = '{b: 8'h05, a: 1'b0, v: 1'b1, w: 10'h0C0};
      t1[5] = '{b: 8'h06, a: 1'b0, v: 1'b1, w: 10'h040};
      t1[6] = '{b: 8'h07, a: 1'b0, v: 1'b1, w: 10'h014};
      t1[7] = '{b: 8'h08, a: 1'b0, v: 1'b0, w: 10'h014};
      t1[8] = '{b: 8'h09, a: 1'b0, v: 1'b1, w: 10'h306};
      t1[9] = '{b: 8'h0A, a: 1'b0, v: 1'b1, w: 10'h201};

      rst_n = 1'b0; din = '0; ain = 1'b0;
      m_locked = 1'b0; m_ph = 0; m_grp = '0;

      // Basic group with align on the first clock after reset release; p2 trails by 2
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cycle(t1[i].b, t1[i].a);
         check_eq("t1 p0 valid", 32'(bus0.valid), 32'(t1[i].v));
         check_eq("t1 p0 data", 32'(bus0.data_out), 32'(t1[i].w));
         if (i >= 2) begin
            check_eq("t6 p2 valid", 32'(bus2.valid), 32'(t1[i-2].v));
            check_eq("t6 p2 data", 32'(bus2.data_out), 32'(t1[i-2].w));
         end
      end

      // All-ones stream, 10 groups
      do_reset();
      vcnt0 = 0; lk_low = 1'b0;
      cycle(8'hFF, 1'b1);
      for (int i = 1; i < 52; i++) begin
         cycle(8'hFF, 1'b0);
         if (i >= 2 && !bus0.locked) lk_low = 1'b1;
      end
      check_eq("t2 word count", 32'(vcnt0), 32'd40);
      check_eq("t2 locked dropped", 32'(lk_low), 32'd0);
      for (int i = 0; i < cap0.size(); i++) begin
         check_eq("t2 word 3FF", 32'(cap0[i]), 32'h3FF);
      end

      // No align: never locks, never valid
      do_reset();
      vcnt0 = 0; lk_seen0 = 0;
      for (int i = 0; i < 50; i++) begin
         cycle(8'($urandom_range(0, 255)), 1'b0);
      end
      check_eq("t3 valid count", 32'(vcnt0), 32'd0);
      check_eq("t3 locked count", 32'(lk_seen0), 32'd0);

      // Re-phase at ph=2
      do_reset();
      cycle(8'h3C, 1'b1);
      cycle(8'h5A, 1'b0);
      cycle(8'h01, 1'b1);
      cycle(8'h02, 1'b0);
      cycle(8'h03, 1'b0);
      cycle(8'h04, 1'b0);
      cycle(8'h05, 1'b0);
      cycle(8'h00, 1'b0);
      cycle(8'h00, 1'b0);
      exp4[0] = 10'h23C; exp4[1] = 10'h201; exp4[2] = 10'h0C0;
      exp4[3] = 10'h040; exp4[4] = 10'h014;
      check_eq("t4 word count", 32'(cap0.size()), 32'd5);
      for (int i = 0; i < 5 && i < cap0.size(); i++) begin
         check_eq("t4 word", 32'(cap0[i]), 32'(exp4[i]));
      end
      cycle(8'h00, 1'b0);
      cycle(8'h00, 1'b0);
`ifdef BUFFER_8TO10_ALIGN_CHECK_EN
      exp_cnt = 8'h01;
`else
      exp_cnt = 8'h00;
`endif
      check_eq("t4 p0 err_cnt", 32'(bus0.align_err_cnt), 32'(exp_cnt));
      check_eq("t4 p2 err_cnt", 32'(bus2.align_err_cnt), 32'(exp_cnt));

      // Reset at ph=3, relock needs a fresh align
      do_reset();
      cycle(8'h11, 1'b1);
      cycle(8'h22, 1'b0);
      cycle(8'h33, 1'b0);
      cycle(8'h44, 1'b0);
      do_reset();
      vcnt0 = 0;
      for (int i = 0; i < 5; i++) cycle(8'($urandom_range(0, 255)), 1'b0);
      check_eq("t5 valid before align", 32'(vcnt0), 32'd0);
      cycle(8'hAA, 1'b1);
      a_edge = edge_n;
      first_edge = -1;
      for (int i = 0; i < 8 && first_edge < 0; i++) begin
         cycle(8'($urandom_range(0, 255)), 1'b0);
         if (bus0.valid) first_edge = edge_n;
      end
      check_eq("t5 relock latency", 32'(first_edge - a_edge), 32'd3);

      // Repeated bad aligns saturate the counter
      do_reset();
      cycle(8'h00, 1'b1);
      for (int i = 0; i < 300; i++) begin
         cycle(8'h00, 1'b0);
         cycle(8'h00, 1'b1);
      end
      for (int i = 0; i < 4; i++) cycle(8'h00, 1'b0);
`ifdef BUFFER_8TO10_ALIGN_CHECK_EN
      exp_cnt = 8'hFF;
`else
      exp_cnt = 8'h00;
`endif
      check_eq("t6 p0 err_cnt sat", 32'(bus0.align_err_cnt), 32'(exp_cnt));
      check_eq("t6 p2 err_cnt sat", 32'(bus2.align_err_cnt), 32'(exp_cnt));
      check_eq("t6 locked", 32'(bus0.locked), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
